// File: rtl/bicubic_upsample_pipe_if.sv
// Window request / upsampled block response bundle between the line-fetch unit,
// the bicubic upsampler and the output packer.
interface bicubic_upsample_pipe_if #(
  parameter int CHANNEL_WIDTH = 8,
  parameter int CHANNELS      = 3
);
  localparam int DATA_W = 16 * CHANNELS * CHANNEL_WIDTH;

  logic              bf_req_valid;
  logic              bcci_req_ready;
  logic              bf_req_mode;
  logic [DATA_W-1:0] bf_req_data;
  logic              bcci_rsp_valid;
  logic              bf_rsp_ready;
  logic [DATA_W-1:0] bcci_rsp_data;

  modport master (
    output bf_req_valid, bf_req_mode, bf_req_data, bf_rsp_ready,
    input  bcci_req_ready, bcci_rsp_valid, bcci_rsp_data
  );

  modport slave (
    input  bf_req_valid, bf_req_mode, bf_req_data, bf_rsp_ready,
    output bcci_req_ready, bcci_rsp_valid, bcci_rsp_data
  );
endinterface

// File: rtl/bicubic_upsample_pipe.sv
// Three-stage separable bicubic 4x upsampler: vertical taps, horizontal taps,
// then round/saturate (or centre replication in nearest mode).
module bicubic_upsample_pipe #(
  parameter int CHANNEL_WIDTH = 8,
  parameter int CHANNELS      = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  bicubic_upsample_pipe_if.slave  bus
);
  localparam int W    = CHANNEL_WIDTH;
  localparam int DW   = 16 * CHANNELS * W;
  localparam int VW   = W + 10;
  localparam int HW   = W + 18;
  localparam int MAXV = (1 << W) - 1;

  // Q1.7 taps; 128 needs a 9-bit signed container.
  function automatic logic signed [8:0] phase_weight(input int phase, input int tap);
    logic signed [8:0] w;
    w = '0;
    case (phase * 4 + tap)
      1:       w = 9'sd128;
      4:       w = -9'sd9;
      5:       w = 9'sd111;
      6:       w = 9'sd29;
      7:       w = -9'sd3;
      8:       w = -9'sd8;
      9:       w = 9'sd72;
      10:      w = 9'sd72;
      11:      w = -9'sd8;
      12:      w = -9'sd3;
      13:      w = 9'sd29;
      14:      w = 9'sd111;
      15:      w = -9'sd9;
      default: w = '0;
    endcase
    return w;
  endfunction

  logic                 v1_reg, v2_reg, v3_reg;
  logic                 mode1_reg, mode2_reg;
  logic [W-1:0]         ctr1_reg [CHANNELS];
  logic [W-1:0]         ctr2_reg [CHANNELS];
  logic signed [VW-1:0] vert1_reg [CHANNELS][16];
  logic signed [HW-1:0] hor2_reg [CHANNELS][16];
  logic [DW-1:0]        out3_reg;

  logic [W-1:0]         ctr_next [CHANNELS];
  logic signed [VW-1:0] vert_next [CHANNELS][16];
  logic signed [HW-1:0] hor_next [CHANNELS][16];
  logic [DW-1:0]        out_next;
  logic signed [HW-1:0] rnd;

  logic en1, en2, en3;

  // Each stage may advance when it is empty or its successor is advancing.
  assign en3 = ~v3_reg | bus.bf_rsp_ready;
  assign en2 = ~v2_reg | en3;
  assign en1 = ~v1_reg | en2;

  assign bus.bcci_req_ready = en1;
  assign bus.bcci_rsp_valid = v3_reg;
  assign bus.bcci_rsp_data  = out3_reg;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ctr
    assign ctr_next[gi] = bus.bf_req_data[(gi*16 + 5)*W +: W];
  end

  // Vertical pass: V(i,c) indexed i*4+c.
  always_comb begin
    for (int ch = 0; ch < CHANNELS; ch++) begin
      for (int i = 0; i < 4; i++) begin
        for (int c = 0; c < 4; c++) begin
          vert_next[ch][i*4 + c] = '0;
          for (int r = 0; r < 4; r++) begin
            vert_next[ch][i*4 + c] = vert_next[ch][i*4 + c]
              + (VW'($signed({1'b0, bus.bf_req_data[(ch*16 + r*4 + c)*W +: W]}))
                 * VW'(phase_weight(i, r)));
          end
        end
      end
    end
  end

  // Horizontal pass: H(i,j) indexed i*4+j.
  always_comb begin
    for (int ch = 0; ch < CHANNELS; ch++) begin
      for (int i = 0; i < 4; i++) begin
        for (int j = 0; j < 4; j++) begin
          hor_next[ch][i*4 + j] = '0;
          for (int c = 0; c < 4; c++) begin
            hor_next[ch][i*4 + j] = hor_next[ch][i*4 + j]
              + (HW'(vert1_reg[ch][i*4 + c]) * HW'(phase_weight(j, c)));
          end
        end
      end
    end
  end

  // Normalise by 2^14 with round-half-up, clamp to the pixel range.
  always_comb begin
    out_next = '0;
    rnd      = '0;
    for (int ch = 0; ch < CHANNELS; ch++) begin
      for (int k = 0; k < 16; k++) begin
        rnd = (hor2_reg[ch][k] + HW'(8192)) >>> 14;
        if (mode2_reg)
          out_next[(ch*16 + k)*W +: W] = ctr2_reg[ch];
        else if (rnd[HW-1])
          out_next[(ch*16 + k)*W +: W] = '0;
        else if (rnd > HW'(MAXV))
          out_next[(ch*16 + k)*W +: W] = W'(MAXV);
        else
          out_next[(ch*16 + k)*W +: W] = rnd[W-1:0];
      end
    end
  end

  // Data registers only load behind a valid so idle-bus contents never enter.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_reg    <= 1'b0;
      v2_reg    <= 1'b0;
      v3_reg    <= 1'b0;
      mode1_reg <= 1'b0;
      mode2_reg <= 1'b0;
      out3_reg  <= '0;
      for (int ch = 0; ch < CHANNELS; ch++) begin
        ctr1_reg[ch] <= '0;
        ctr2_reg[ch] <= '0;
        for (int k = 0; k < 16; k++) begin
          vert1_reg[ch][k] <= '0;
          hor2_reg[ch][k]  <= '0;
        end
      end
    end else begin
      if (en1) begin
        v1_reg <= bus.bf_req_valid;
        if (bus.bf_req_valid) begin
          mode1_reg <= bus.bf_req_mode;
          ctr1_reg  <= ctr_next;
          vert1_reg <= vert_next;
        end
      end
      if (en2) begin
        v2_reg <= v1_reg;
        if (v1_reg) begin
          mode2_reg <= mode1_reg;
          ctr2_reg  <= ctr1_reg;
          hor2_reg  <= hor_next;
        end
      end
      if (en3) begin
        v3_reg <= v2_reg;
        if (v2_reg)
          out3_reg <= out_next;
      end
    end
  end
endmodule
